// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: fixed-latency busy counter, HI/LO ownership, D-stage stall.
// Optional build macro: MDU_MADD_EN enables madd/maddu (Op 9/10) multiply-accumulate.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    input  logic [3:0]  E_MDU_Op,
    input  logic        D_MDU_Use,
    output logic        E_MDU_Busy,
    output logic        E_MDU_Stall,
    output logic [31:0] E_MDU_Out,
    output logic [31:0] E_MDU_HI,
    output logic [31:0] E_MDU_LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
`endif

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e         state_q;
    logic [CW-1:0]  cnt_q;
    logic [31:0]    a_q, b_q, hi_q, lo_q;
    logic [3:0]     op_q;
    logic [31:0]    hi_d, lo_d;
    logic           start;
    logic           is_div;

    logic [63:0]        prod_s, prod_u;
    logic signed [32:0] quot_s, rem_s;

    // 33-bit signed division keeps INT_MIN / -1 representable instead of overflowing.
    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'b0, a_q} * {32'b0, b_q};
    assign quot_s = $signed({a_q[31], a_q}) / $signed({b_q[31], b_q});
    assign rem_s  = $signed({a_q[31], a_q}) % $signed({b_q[31], b_q});

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        start = 1'b0;
        if (state_q == IDLE) begin
            case (E_MDU_Op)
                OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: start = 1'b1;
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU:                  start = 1'b1;
`endif
                default:                            start = 1'b0;
            endcase
        end
    end

    assign is_div = (E_MDU_Op == OP_DIV) || (E_MDU_Op == OP_DIVU);

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (op_q)
            OP_MULT:  {hi_d, lo_d} = prod_s;
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
                if (b_q != 32'd0) begin
                    lo_d = quot_s[31:0];
                    hi_d = rem_s[31:0];
                end
            end
            OP_DIVU: begin
                if (b_q != 32'd0) begin
                    lo_d = a_q / b_q;
                    hi_d = a_q % b_q;
                end
            end
`ifdef MDU_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= E_MDU_A;
                        b_q     <= E_MDU_B;
                        op_q    <= E_MDU_Op;
                        cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_q <= BUSY;
                    end else if (E_MDU_Op == OP_MTHI) begin
                        hi_q <= E_MDU_A;
                    end else if (E_MDU_Op == OP_MTLO) begin
                        lo_q <= E_MDU_A;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        hi_q    <= hi_d;
                        lo_q    <= lo_d;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign E_MDU_Busy  = (state_q == BUSY);
    assign E_MDU_Stall = D_MDU_Use & (start | E_MDU_Busy);
    assign E_MDU_HI    = hi_q;
    assign E_MDU_LO    = lo_q;
    assign E_MDU_Out   = (E_MDU_Op == OP_MFHI) ? hi_q :
                         (E_MDU_Op == OP_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random op stream vs. an arithmetic HI/LO model.
module tb_md_unit;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] E_MDU_A, E_MDU_B;
    logic [3:0]  E_MDU_Op;
    logic        D_MDU_Use;
    logic        E_MDU_Busy, E_MDU_Stall;
    logic [31:0] E_MDU_Out, E_MDU_HI, E_MDU_LO;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] hi_m, lo_m;

    md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDU_A    (E_MDU_A),
        .E_MDU_B    (E_MDU_B),
        .E_MDU_Op   (E_MDU_Op),
        .D_MDU_Use  (D_MDU_Use),
        .E_MDU_Busy (E_MDU_Busy),
        .E_MDU_Stall(E_MDU_Stall),
        .E_MDU_Out  (E_MDU_Out),
        .E_MDU_HI   (E_MDU_HI),
        .E_MDU_LO   (E_MDU_LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit madd_en();
`ifdef MDU_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit starts_op(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd4) || (madd_en() && (op == 4'd9 || op == 4'd10));
    endfunction

    // Architectural effect of a completed long operation on the HI/LO model.
    task automatic model_commit(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p, acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        acc = {hi_m, lo_m};
        case (op)
            4'd1: begin p = 64'(sa * sb); {hi_m, lo_m} = p; end
            4'd2: begin p = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = p; end
            4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; lo_m = q[31:0]; hi_m = r[31:0]; end
            4'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            4'd9: begin p = 64'(sa * sb); {hi_m, lo_m} = acc + p; end
            4'd10: begin p = {32'b0, a} * {32'b0, b}; {hi_m, lo_m} = acc + p; end
            default: ;
        endcase
    endtask

    // Issue one op at cycle 0; optionally inject another op at busy cycle inj_cyc (should be ignored).
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, input int inj_cyc, input logic [3:0] inj_op,
                          input logic [31:0] inj_a);
        int          n;
        bit          st;
        logic [31:0] exp_out;
        st = starts_op(op);
        n  = (op == 4'd3 || op == 4'd4) ? DIV_CYCLES : MULT_CYCLES;
        exp_out = (op == 4'd7) ? hi_m : (op == 4'd8) ? lo_m : 32'd0;
        E_MDU_Op = op; E_MDU_A = a; E_MDU_B = b; D_MDU_Use = use_d;
        #1;
        check("busy_c0", E_MDU_Busy, 0);
        check("stall_c0", E_MDU_Stall, use_d & st);
        check("out_c0", E_MDU_Out, exp_out);
        @(posedge clk); #1;
        if (!st) begin
            if (op == 4'd5) hi_m = a;
            if (op == 4'd6) lo_m = a;
            E_MDU_Op = 4'd0;
            #1;
            check("busy_single", E_MDU_Busy, 0);
            check("hi_single", E_MDU_HI, hi_m);
            check("lo_single", E_MDU_LO, lo_m);
            return;
        end
        for (int c = 1; c <= n; c++) begin
            E_MDU_Op = (c == inj_cyc) ? inj_op : 4'd0;
            E_MDU_A  = (c == inj_cyc) ? inj_a : $urandom;
            E_MDU_B  = $urandom;
            #1;
            check("busy_run", E_MDU_Busy, 1);
            check("stall_run", E_MDU_Stall, use_d);
            check("hi_hold", E_MDU_HI, hi_m);
            check("lo_hold", E_MDU_LO, lo_m);
            @(posedge clk); #1;
        end
        E_MDU_Op = 4'd0;
        model_commit(op, a, b);
        #1;
        check("busy_done", E_MDU_Busy, 0);
        check("stall_done", E_MDU_Stall, 0);
        check("hi_done", E_MDU_HI, hi_m);
        check("lo_done", E_MDU_LO, lo_m);
    endtask

    initial begin
        reset = 1'b1; E_MDU_Op = 4'd0; E_MDU_A = '0; E_MDU_B = '0; D_MDU_Use = 1'b0;
        hi_m = '0; lo_m = '0;
        #3;
        check("rst_busy", E_MDU_Busy, 0);
        check("rst_stall", E_MDU_Stall, 0);
        check("rst_hi", E_MDU_HI, 0);
        check("rst_lo", E_MDU_LO, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;

        run_op(4'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 0, 4'd0, 0);
        check("mult_hi_lit", E_MDU_HI, 32'hFFFF_FFFF);
        check("mult_lo_lit", E_MDU_LO, 32'hFFFF_FFFE);
        run_op(4'd2, 32'hFFFF_FFFF, 32'h2, 1'b0, 0, 4'd0, 0);
        check("multu_hi_lit", E_MDU_HI, 32'h1);
        run_op(4'd7, 0, 0, 1'b0, 0, 4'd0, 0);
        run_op(4'd3, 32'hFFFF_FFF9, 32'h2, 1'b1, 0, 4'd0, 0);
        check("div_lo_lit", E_MDU_LO, 32'hFFFF_FFFD);
        check("div_hi_lit", E_MDU_HI, 32'hFFFF_FFFF);

        run_op(4'd5, 32'hA, 0, 1'b0, 0, 4'd0, 0);
        run_op(4'd6, 32'hB, 0, 1'b0, 0, 4'd0, 0);
        run_op(4'd4, 32'h1234, 32'h0, 1'b1, 3, 4'd5, 32'h55);
        check("divz_hi_lit", E_MDU_HI, 32'hA);
        check("divz_lo_lit", E_MDU_LO, 32'hB);

        run_op(4'd6, 32'h0000_BEEF, 0, 1'b1, 0, 4'd0, 0);
        run_op(4'd8, 0, 0, 1'b1, 0, 4'd0, 0);

        // Asynchronous reset in the middle of a multiply.
        E_MDU_Op = 4'd1; E_MDU_A = 32'h1234_5678; E_MDU_B = 32'h9; D_MDU_Use = 1'b0;
        repeat (3) begin @(posedge clk); #1; E_MDU_Op = 4'd0; end
        #2; reset = 1'b1; #1;
        hi_m = '0; lo_m = '0;
        check("arst_busy", E_MDU_Busy, 0);
        check("arst_hi", E_MDU_HI, 0);
        check("arst_lo", E_MDU_LO, 0);
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        run_op(4'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, 0, 4'd0, 0);

        run_op(4'd5, 32'h0, 0, 1'b0, 0, 4'd0, 0);
        run_op(4'd6, 32'h1, 0, 1'b0, 0, 4'd0, 0);
        run_op(4'd10, 32'h2, 32'h3, 1'b1, 0, 4'd0, 0);
`ifdef MDU_MADD_EN
        check("maddu_lo_lit", E_MDU_LO, 32'h7);
`else
        check("maddu_off_lo", E_MDU_LO, 32'h1);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  op, iop;
            logic [31:0] a, b;
            op  = 4'($urandom_range(0, 15));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'($signed(-32'sd1) * $signed(32'($urandom_range(0, 100))));
            iop = 4'($urandom_range(1, 6));
            run_op(op, a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 4), iop, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit and scheduler for the E stage of the pipelined MIPS core. Accepts mult/multu/div/divu, mthi/mtlo and mfhi/mflo from the E-stage instruction. Models fixed multi-cycle latency with a busy counter and owns the HI/LO registers. Drives the stall request that holds any MD-class instruction in D while the unit is occupied.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd/maddu), ≥1
- DIV_CYCLES, 10: busy cycles for div/divu, ≥1
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- E_MDU_A  in  32  rs operand (forwarded)
- E_MDU_B  in  32  rt operand (forwarded)
- E_MDU_Op  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9 madd, 10 maddu, others none
- D_MDU_Use  in  1  D-stage instruction is any MD-class op (1–10)
- E_MDU_Busy  out  1  operation in flight
- E_MDU_Stall  out  1  stall request to hazard unit
- E_MDU_Out  out  32  mfhi → HI, mflo → LO, else 0
- E_MDU_HI  out  32  architectural HI
- E_MDU_LO  out  32  architectural LO

## Operation
- States: IDLE, BUSY. A down-counter `cnt` holds the remaining busy cycles.
- Start condition: IDLE and Op ∈ {1,2,3,4,9,10}, plus the Configuration gate for 9/10.
  - Latch A, B and Op.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- BUSY: `cnt` decrements each edge. On the edge where `cnt`==1, commit the result to HI/LO and return to IDLE.
- Arithmetic on the latched operands:
  - mult: {HI,LO} = signed 32×32 → 64.
  - multu: {HI,LO} = unsigned 32×32 → 64.
  - div: LO = quotient truncated toward zero; HI = remainder, taking the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - madd/maddu: {HI,LO} += signed/unsigned product, modulo 2^64.
- Divide by zero: takes the full DIV_CYCLES busy time. HI and LO are left unchanged.
- mthi/mtlo in IDLE: HI or LO ← A on that edge, single cycle, Busy stays 0.
- Any Op arriving while BUSY (mthi, mtlo, start ops) is ignored. The stall guarantees this never occurs in normal flow.
- mfhi/mflo: E_MDU_Out is combinational from the current HI/LO. It is never issued during BUSY because of the stall.
- E_MDU_Stall = D_MDU_Use & (start condition | E_MDU_Busy).
- Non-MD Op values have no effect.

## Timing
- Reset values: Busy 0, Stall 0 (while D_MDU_Use=0), HI 0, LO 0, `cnt` 0, state IDLE.
- Reset asserted mid-operation aborts immediately and asynchronously: Busy 0, HI/LO 0, no commit.
- Start cycle is cycle 0 (Busy 0, Stall driven by the start condition). Busy is 1 on cycles 1..N.
- HI/LO hold new values from cycle N+1, which is also the first cycle Busy=0.
- A back-to-back start is accepted in cycle N+1.
- A D-stage MD instruction behind a start stalls for N+1 cycles.
- mthi/mtlo: write is visible on the next cycle. An mfhi in the following cycle reads the new value.

## Configuration
- `MDU_MADD_EN`
  - Defined: Op 9/10 (madd/maddu) start a MULT_CYCLES accumulate operation.
  - Undefined: Op 9/10 behave as Op 0 (no start, no Busy, HI/LO unchanged). Multiply-accumulate logic is not synthesized.

## Test plan
- mult A=0xFFFFFFFF, B=0x00000002 → Busy 1 for cycles 1–5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu same operands → HI=0x00000001, LO=0xFFFFFFFE; then mfhi gives Out=0x00000001.
- div A=0xFFFFFFF9 (−7), B=2 with D_MDU_Use held 1 → Stall 1 for 11 cycles, Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=0x1234, B=0 with prior HI=0xA, LO=0xB → Busy 10 cycles; HI=0xA, LO=0xB unchanged. mthi 0x55 issued at cycle 3 is ignored.
- mtlo 0x0000BEEF, then next cycle mflo → Out=0x0000BEEF, Busy never asserted.
- reset pulse during cycle 3 of mult → Busy 0 and HI=LO=0 without waiting for a clock edge; the next mult behaves as in scenario 1. With MDU_MADD_EN defined: HI=0, LO=1, then maddu 2×3 → LO=7 after 5 busy cycles.
